// File: rtl/sdram_tribuf_sched_if.sv
// Event and address/status bundle between the frame writer/display logic and the
// triple-buffer scheduler that steers the SDRAM read and write ports.
interface sdram_tribuf_sched_if;
   logic        sdram_init_done;
   logic        wr_frame_start;
   logic        wr_frame_end;
   logic        rd_frame_start;
   logic [23:0] wr_min_addr;
   logic [23:0] wr_max_addr;
   logic        wr_load;
   logic [23:0] rd_min_addr;
   logic [23:0] rd_max_addr;
   logic        rd_load;
   logic        sdram_read_valid;
   logic [1:0]  cur_wr_buf;
   logic [1:0]  cur_rd_buf;
   logic [15:0] drop_cnt;
   logic [15:0] repeat_cnt;

   modport master (
      output sdram_init_done, wr_frame_start, wr_frame_end, rd_frame_start,
      input  wr_min_addr, wr_max_addr, wr_load, rd_min_addr, rd_max_addr, rd_load,
      input  sdram_read_valid, cur_wr_buf, cur_rd_buf, drop_cnt, repeat_cnt
   );

   modport slave (
      input  sdram_init_done, wr_frame_start, wr_frame_end, rd_frame_start,
      output wr_min_addr, wr_max_addr, wr_load, rd_min_addr, rd_max_addr, rd_load,
      output sdram_read_valid, cur_wr_buf, cur_rd_buf, drop_cnt, repeat_cnt
   );
endinterface

// File: rtl/sdram_tribuf_sched.sv
// Triple-buffer scheduler: the writer never touches the displayed buffer and the
// reader always picks up the newest completed frame.
module sdram_tribuf_sched #(
   parameter logic [23:0] BASE_ADDR   = 24'h000000,
   parameter logic [23:0] FRAME_SIZE  = 24'h04B000,
   parameter int unsigned LOAD_CYCLES = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   sdram_tribuf_sched_if.slave bus
);

   localparam logic [25:0] END_CHK = {2'b00, BASE_ADDR} + {2'b00, FRAME_SIZE}
                                   + {2'b00, FRAME_SIZE} + {2'b00, FRAME_SIZE};
   localparam logic [23:0] BASE0 = BASE_ADDR;
   localparam logic [23:0] BASE1 = BASE_ADDR + FRAME_SIZE;
   localparam logic [23:0] BASE2 = BASE_ADDR + FRAME_SIZE + FRAME_SIZE;
   localparam logic [3:0]  LOAD_INIT = 4'(LOAD_CYCLES);

   generate
      if (END_CHK > 26'h1000000) begin : g_bad_frame_size
         $error("sdram_tribuf_sched: three frames do not fit in 24-bit address space");
      end
      if ((LOAD_CYCLES < 1) || (LOAD_CYCLES > 15)) begin : g_bad_load_cycles
         $error("sdram_tribuf_sched: LOAD_CYCLES must be 1..15");
      end
   endgenerate

   function automatic logic [23:0] base_of(input logic [1:0] idx);
      case (idx)
         2'd0:    base_of = BASE0;
         2'd1:    base_of = BASE1;
         2'd2:    base_of = BASE2;
         default: base_of = BASE0;
      endcase
   endfunction

   // Lowest buffer that is neither displayed nor holding an unread complete frame.
   function automatic logic [1:0] pick_free(input logic [1:0] rd, input logic [1:0] rdy,
                                            input logic vld);
      if ((rd != 2'd0) && !(vld && (rdy == 2'd0))) begin
         pick_free = 2'd0;
      end else if ((rd != 2'd1) && !(vld && (rdy == 2'd1))) begin
         pick_free = 2'd1;
      end else begin
         pick_free = 2'd2;
      end
   endfunction

   logic [1:0]  wr_idx_r, rd_idx_r, rdy_idx_r;
   logic        rdy_vld_r, wr_active_r, read_valid_r;
   logic [15:0] drop_r, repeat_r;
   logic [3:0]  wr_cnt_r, rd_cnt_r;
   logic        wr_load_r, rd_load_r;
   logic [23:0] wr_min_r, wr_max_r, rd_min_r, rd_max_r;

   logic [1:0]  wr_idx_s, rd_idx_s, rdy_idx_s;
   logic        rdy_vld_s, wr_active_s, read_valid_s;
   logic [15:0] drop_s, repeat_s;
   logic        wr_trig_s, rd_trig_s;
   logic [3:0]  wr_cnt_s, rd_cnt_s;

   // Next-state evaluation: frame end, then read start, then write start, each on next-state values.
   always_comb begin
      wr_idx_s     = wr_idx_r;
      rd_idx_s     = rd_idx_r;
      rdy_idx_s    = rdy_idx_r;
      rdy_vld_s    = rdy_vld_r;
      wr_active_s  = wr_active_r;
      read_valid_s = read_valid_r;
      drop_s       = drop_r;
      repeat_s     = repeat_r;
      wr_trig_s    = 1'b0;
      rd_trig_s    = 1'b0;
      if (bus.sdram_init_done) begin
         if (bus.wr_frame_end && wr_active_s) begin
            if (rdy_vld_s) begin
               drop_s = drop_s + 16'd1;
            end else begin
               drop_s = drop_s;
            end
            rdy_idx_s   = wr_idx_s;
            rdy_vld_s   = 1'b1;
            wr_active_s = 1'b0;
         end else begin
            wr_active_s = wr_active_s;
         end
         if (bus.rd_frame_start) begin
            rd_trig_s = 1'b1;
            if (rdy_vld_s) begin
               rd_idx_s     = rdy_idx_s;
               rdy_vld_s    = 1'b0;
               read_valid_s = 1'b1;
            end else if (read_valid_s) begin
               repeat_s = repeat_s + 16'd1;
            end else begin
               repeat_s = repeat_s;
            end
         end else begin
            rd_trig_s = 1'b0;
         end
         if (bus.wr_frame_start) begin
            if (wr_active_s) begin
               drop_s = drop_s + 16'd1;
            end else begin
               drop_s = drop_s;
            end
            wr_idx_s    = pick_free(rd_idx_s, rdy_idx_s, rdy_vld_s);
            wr_active_s = 1'b1;
            wr_trig_s   = 1'b1;
         end else begin
            wr_trig_s = 1'b0;
         end
      end else begin
         wr_trig_s = 1'b0;
      end

      if (wr_trig_s) begin
         wr_cnt_s = LOAD_INIT;
      end else if (wr_cnt_r != 4'd0) begin
         wr_cnt_s = wr_cnt_r - 4'd1;
      end else begin
         wr_cnt_s = 4'd0;
      end
      if (rd_trig_s) begin
         rd_cnt_s = LOAD_INIT;
      end else if (rd_cnt_r != 4'd0) begin
         rd_cnt_s = rd_cnt_r - 4'd1;
      end else begin
         rd_cnt_s = 4'd0;
      end
   end

   // State, pulse counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx_r     <= 2'd0;
         rd_idx_r     <= 2'd2;
         rdy_idx_r    <= 2'd2;
         rdy_vld_r    <= 1'b0;
         wr_active_r  <= 1'b0;
         read_valid_r <= 1'b0;
         drop_r       <= 16'd0;
         repeat_r     <= 16'd0;
         wr_cnt_r     <= 4'd0;
         rd_cnt_r     <= 4'd0;
         wr_load_r    <= 1'b0;
         rd_load_r    <= 1'b0;
         wr_min_r     <= BASE0;
         wr_max_r     <= BASE0 + FRAME_SIZE;
         rd_min_r     <= BASE2;
         rd_max_r     <= BASE2 + FRAME_SIZE;
      end else begin
         wr_idx_r     <= wr_idx_s;
         rd_idx_r     <= rd_idx_s;
         rdy_idx_r    <= rdy_idx_s;
         rdy_vld_r    <= rdy_vld_s;
         wr_active_r  <= wr_active_s;
         read_valid_r <= read_valid_s;
         drop_r       <= drop_s;
         repeat_r     <= repeat_s;
         wr_cnt_r     <= wr_cnt_s;
         rd_cnt_r     <= rd_cnt_s;
         wr_load_r    <= (wr_cnt_s != 4'd0);
         rd_load_r    <= (rd_cnt_s != 4'd0);
         wr_min_r     <= base_of(wr_idx_s);
         wr_max_r     <= base_of(wr_idx_s) + FRAME_SIZE;
         rd_min_r     <= base_of(rd_idx_s);
         rd_max_r     <= base_of(rd_idx_s) + FRAME_SIZE;
      end
   end

   assign bus.wr_min_addr      = wr_min_r;
   assign bus.wr_max_addr      = wr_max_r;
   assign bus.wr_load          = wr_load_r;
   assign bus.rd_min_addr      = rd_min_r;
   assign bus.rd_max_addr      = rd_max_r;
   assign bus.rd_load          = rd_load_r;
   assign bus.sdram_read_valid = read_valid_r;
   assign bus.cur_wr_buf       = wr_idx_r;
   assign bus.cur_rd_buf       = rd_idx_r;
   assign bus.drop_cnt         = drop_r;
   assign bus.repeat_cnt       = repeat_r;

endmodule

// File: tb/tb_sdram_tribuf_sched.sv
// Directed bench for the triple-buffer scheduler with hand-computed expectations.
module tb_sdram_tribuf_sched;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   sdram_tribuf_sched_if bus ();

   sdram_tribuf_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge; the buffer invariant is checked every cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst_n && dut.wr_active_r && bus.sdram_read_valid) begin
         n_chk = n_chk + 1;
         assert (bus.cur_wr_buf !== bus.cur_rd_buf) else begin
            n_fail = n_fail + 1;
            $error("FAIL invariant: wr_buf %0d rd_buf %0d", bus.cur_wr_buf, bus.cur_rd_buf);
         end
      end
   endtask

   // Expects the load (rd=1 selects rd_load) already high at this sample: 3 more high, then low.
   task automatic load_window(input string tag, input bit rd);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk(tag, 32'(rd ? bus.rd_load : bus.wr_load), 32'd1);
      end
      tick();
      chk(tag, 32'(rd ? bus.rd_load : bus.wr_load), 32'd0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_wr_min"}, 32'(bus.wr_min_addr), 32'h000000);
      chk({tag, "_wr_max"}, 32'(bus.wr_max_addr), 32'h04B000);
      chk({tag, "_rd_min"}, 32'(bus.rd_min_addr), 32'h096000);
      chk({tag, "_rd_max"}, 32'(bus.rd_max_addr), 32'h0E1000);
      chk({tag, "_wr_load"}, 32'(bus.wr_load), 32'd0);
      chk({tag, "_rd_load"}, 32'(bus.rd_load), 32'd0);
      chk({tag, "_valid"}, 32'(bus.sdram_read_valid), 32'd0);
      chk({tag, "_wr_buf"}, 32'(bus.cur_wr_buf), 32'd0);
      chk({tag, "_rd_buf"}, 32'(bus.cur_rd_buf), 32'd2);
      chk({tag, "_drop"}, 32'(bus.drop_cnt), 32'd0);
      chk({tag, "_repeat"}, 32'(bus.repeat_cnt), 32'd0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.sdram_init_done = 1'b0;
      bus.wr_frame_start  = 1'b0;
      bus.wr_frame_end    = 1'b0;
      bus.rd_frame_start  = 1'b0;
      tick();
      tick();
      check_reset_state("reset");

      // Events are ignored until SDRAM init is done
      rst_n = 1'b1;
      tick();
      bus.wr_frame_start = 1'b1;
      tick();
      bus.wr_frame_start = 1'b0;
      chk("noinit_wr_load", 32'(bus.wr_load), 32'd0);
      tick();
      chk("noinit_wr_load2", 32'(bus.wr_load), 32'd0);

      // 1: first write frame goes to buffer 0
      bus.sdram_init_done = 1'b1;
      bus.wr_frame_start  = 1'b1;
      tick();
      bus.wr_frame_start = 1'b0;
      chk("t1_wr_load", 32'(bus.wr_load), 32'd1);
      chk("t1_wr_min", 32'(bus.wr_min_addr), 32'h000000);
      chk("t1_wr_max", 32'(bus.wr_max_addr), 32'h04B000);
      chk("t1_wr_buf", 32'(bus.cur_wr_buf), 32'd0);
      load_window("t1_wr_window", 1'b0);

      // 2: complete it, hand it to the reader, next write goes to buffer 1
      bus.wr_frame_end = 1'b1;
      tick();
      bus.wr_frame_end = 1'b0;
      chk("t2_valid_before", 32'(bus.sdram_read_valid), 32'd0);
      bus.rd_frame_start = 1'b1;
      tick();
      bus.rd_frame_start = 1'b0;
      chk("t2_rd_load", 32'(bus.rd_load), 32'd1);
      chk("t2_rd_min", 32'(bus.rd_min_addr), 32'h000000);
      chk("t2_rd_max", 32'(bus.rd_max_addr), 32'h04B000);
      chk("t2_valid", 32'(bus.sdram_read_valid), 32'd1);
      chk("t2_rd_buf", 32'(bus.cur_rd_buf), 32'd0);
      load_window("t2_rd_window", 1'b1);
      bus.wr_frame_start = 1'b1;
      tick();
      bus.wr_frame_start = 1'b0;
      chk("t2_wr_min", 32'(bus.wr_min_addr), 32'h04B000);
      chk("t2_wr_max", 32'(bus.wr_max_addr), 32'h096000);
      chk("t2_wr_buf", 32'(bus.cur_wr_buf), 32'd1);
      load_window("t2_wr_window", 1'b0);

      // 3: two frames finish (buf1, buf2) before the reader asks; buf1 is dropped
      bus.wr_frame_end = 1'b1;
      tick();
      bus.wr_frame_end   = 1'b0;
      bus.wr_frame_start = 1'b1;
      tick();
      bus.wr_frame_start = 1'b0;
      chk("t3_wr_buf_a", 32'(bus.cur_wr_buf), 32'd2);
      chk("t3_wr_min_a", 32'(bus.wr_min_addr), 32'h096000);
      bus.wr_frame_end = 1'b1;
      tick();
      bus.wr_frame_end = 1'b0;
      chk("t3_drop", 32'(bus.drop_cnt), 32'd1);
      tick();
      tick();
      tick();
      tick();
      bus.wr_frame_start = 1'b1;
      tick();
      bus.wr_frame_start = 1'b0;
      chk("t3_wr_buf_b", 32'(bus.cur_wr_buf), 32'd1);
      chk("t3_wr_min_b", 32'(bus.wr_min_addr), 32'h04B000);
      bus.rd_frame_start = 1'b1;
      tick();
      bus.rd_frame_start = 1'b0;
      chk("t3_rd_min", 32'(bus.rd_min_addr), 32'h096000);
      chk("t3_rd_max", 32'(bus.rd_max_addr), 32'h0E1000);
      chk("t3_rd_buf", 32'(bus.cur_rd_buf), 32'd2);
      chk("t3_drop_hold", 32'(bus.drop_cnt), 32'd1);
      load_window("t3_rd_window", 1'b1);

      // 4: reader asks again with nothing new: repeat, buffer unchanged
      bus.rd_frame_start = 1'b1;
      tick();
      bus.rd_frame_start = 1'b0;
      chk("t4_rd_load", 32'(bus.rd_load), 32'd1);
      chk("t4_repeat", 32'(bus.repeat_cnt), 32'd1);
      chk("t4_rd_buf", 32'(bus.cur_rd_buf), 32'd2);
      chk("t4_rd_min", 32'(bus.rd_min_addr), 32'h096000);
      load_window("t4_rd_window", 1'b1);

      // 5: end + read start + write start in one cycle
      bus.wr_frame_end   = 1'b1;
      bus.rd_frame_start = 1'b1;
      bus.wr_frame_start = 1'b1;
      tick();
      bus.wr_frame_end   = 1'b0;
      bus.rd_frame_start = 1'b0;
      bus.wr_frame_start = 1'b0;
      chk("t5_rd_buf", 32'(bus.cur_rd_buf), 32'd1);
      chk("t5_rd_min", 32'(bus.rd_min_addr), 32'h04B000);
      chk("t5_wr_buf", 32'(bus.cur_wr_buf), 32'd0);
      chk("t5_wr_min", 32'(bus.wr_min_addr), 32'h000000);
      chk("t5_drop", 32'(bus.drop_cnt), 32'd1);
      chk("t5_repeat", 32'(bus.repeat_cnt), 32'd1);
      chk("t5_wr_load", 32'(bus.wr_load), 32'd1);
      chk("t5_rd_load", 32'(bus.rd_load), 32'd1);

      // 6: asynchronous reset in the middle of a load pulse
      tick();
      chk("t6_wr_load_pre", 32'(bus.wr_load), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_state("t6_async");
      tick();
      rst_n = 1'b1;
      bus.wr_frame_end = 1'b1;
      tick();
      bus.wr_frame_end   = 1'b0;
      bus.rd_frame_start = 1'b1;
      tick();
      bus.rd_frame_start = 1'b0;
      chk("t6_rd_load", 32'(bus.rd_load), 32'd1);
      chk("t6_valid", 32'(bus.sdram_read_valid), 32'd0);
      chk("t6_rd_buf", 32'(bus.cur_rd_buf), 32'd2);
      chk("t6_repeat", 32'(bus.repeat_cnt), 32'd0);
      chk("t6_drop", 32'(bus.drop_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
